// File: rtl/uart_rx_stream_decoder.sv
// 8N1 UART receiver for the MCU UART0 TXD tap: strips ESC command pairs,
// drives DEBUG_TESTER_ENABLE / EOT and queues plain characters in a FIFO.
module uart_rx_stream_decoder #(
   parameter int unsigned BAUDDIV    = 16,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned FIFO_AW    = 3
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               RXD,
   output logic [7:0]         RX_DATA,
   output logic               RX_VALID,
   input  logic               RX_READY,
   output logic [FIFO_AW:0]   FIFO_LEVEL,
   output logic               DEBUG_TESTER_ENABLE,
   output logic               EOT,
   output logic               FRAME_ERR,
   output logic               OVERRUN,
   output logic               CMD_ERR
);

   localparam logic [15:0] CNT_HALF   = 16'(BAUDDIV / 2 - 1);
   localparam logic [15:0] CNT_FULL   = 16'(BAUDDIV - 1);
   localparam logic [7:0]  CH_ESC     = 8'h1B;
   localparam logic [7:0]  CH_EOT     = 8'h04;
   localparam logic [7:0]  CH_DTE_ON  = 8'h11;
   localparam logic [7:0]  CH_DTE_OFF = 8'h12;

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} rx_state_t;
   typedef enum logic {CMD_NORMAL, CMD_ESC} cmd_state_t;
   typedef logic [FIFO_AW:0] ptr_t;

   logic       rxd_meta;
   logic       rxd_s;
   rx_state_t  rx_state;
   logic [15:0] cnt;
   logic [2:0] bit_idx;
   logic [7:0] rx_byte;
   logic       byte_done;
   cmd_state_t cmd_state;

   logic [7:0] mem [FIFO_DEPTH];
   ptr_t       wr_ptr;
   ptr_t       rd_ptr;
   ptr_t       wr_next;
   ptr_t       rd_next;
   ptr_t       level_next;
   logic       push;
   logic       full;
   logic       do_push;
   logic       do_pop;
   logic       overrun_now;
   logic [7:0] head_next;

   // Synchroniser idles high so reset never looks like a start edge
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rxd_meta <= 1'b1;
         rxd_s    <= 1'b1;
      end else begin
         rxd_meta <= RXD;
         rxd_s    <= rxd_meta;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rx_state  <= ST_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         rx_byte   <= '0;
         byte_done <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else begin
         byte_done <= 1'b0;
         FRAME_ERR <= 1'b0;
         case (rx_state)
            ST_IDLE: begin
               if (!rxd_s) begin
                  cnt      <= CNT_HALF;
                  rx_state <= ST_START;
               end
            end
            ST_START: begin
               if (cnt == '0) begin
                  if (rxd_s) begin
                     rx_state <= ST_IDLE;
                  end else begin
                     cnt      <= CNT_FULL;
                     bit_idx  <= '0;
                     rx_state <= ST_DATA;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            ST_DATA: begin
               if (cnt == '0) begin
                  rx_byte[bit_idx] <= rxd_s;
                  cnt              <= CNT_FULL;
                  if (bit_idx == 3'd7) rx_state <= ST_STOP;
                  else                 bit_idx  <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            ST_STOP: begin
               if (cnt == '0) begin
                  if (rxd_s) begin
                     byte_done <= 1'b1;
                     rx_state  <= ST_IDLE;
                  end else begin
                     FRAME_ERR <= 1'b1;
                     rx_state  <= ST_BREAK;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            ST_BREAK: begin
               if (rxd_s) rx_state <= ST_IDLE;
            end
            default: rx_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cmd_state           <= CMD_NORMAL;
         DEBUG_TESTER_ENABLE <= 1'b0;
         EOT                 <= 1'b0;
         CMD_ERR             <= 1'b0;
      end else begin
         EOT     <= 1'b0;
         CMD_ERR <= 1'b0;
         if (FRAME_ERR) begin
            cmd_state <= CMD_NORMAL;
         end else if (byte_done) begin
            case (cmd_state)
               CMD_NORMAL: begin
                  if (rx_byte == CH_ESC)      cmd_state <= CMD_ESC;
                  else if (rx_byte == CH_EOT) EOT       <= 1'b1;
               end
               CMD_ESC: begin
                  if (rx_byte != CH_ESC) cmd_state <= CMD_NORMAL;
                  if (rx_byte == CH_DTE_ON)       DEBUG_TESTER_ENABLE <= 1'b1;
                  else if (rx_byte == CH_DTE_OFF) DEBUG_TESTER_ENABLE <= 1'b0;
                  else if (rx_byte != CH_ESC)     CMD_ERR             <= 1'b1;
               end
               default: cmd_state <= CMD_NORMAL;
            endcase
         end
      end
   end

   assign push = byte_done && (cmd_state == CMD_NORMAL) && (rx_byte != CH_ESC);
   assign full = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

   // RX_DATA is registered, so the head after this edge is computed here,
   // bypassing the incoming byte when it lands in the new head slot.
   always_comb begin
      do_pop      = RX_VALID && RX_READY;
      do_push     = push && (!full || do_pop);
      overrun_now = push && full && !do_pop;
      wr_next     = wr_ptr + ptr_t'(do_push);
      rd_next     = rd_ptr + ptr_t'(do_pop);
      level_next  = wr_next - rd_next;
      head_next   = RX_DATA;
      if (level_next != '0) begin
         if (do_push && (wr_ptr[FIFO_AW-1:0] == rd_next[FIFO_AW-1:0]))
            head_next = rx_byte;
         else
            head_next = mem[rd_next[FIFO_AW-1:0]];
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= rx_byte;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         FIFO_LEVEL <= '0;
         RX_VALID   <= 1'b0;
         RX_DATA    <= '0;
         OVERRUN    <= 1'b0;
      end else begin
         wr_ptr     <= wr_next;
         rd_ptr     <= rd_next;
         FIFO_LEVEL <= level_next;
         RX_VALID   <= (level_next != '0);
         RX_DATA    <= head_next;
         OVERRUN    <= overrun_now;
      end
   end

endmodule

// File: tb/tb_uart_rx_stream_decoder.sv
// Directed bench for uart_rx_stream_decoder at BAUDDIV=16, FIFO_DEPTH=8.
module tb_uart_rx_stream_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [3:0] fifo_level;
   logic       dte;
   logic       eot;
   logic       frame_err;
   logic       overrun;
   logic       cmd_err;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   int unsigned eot_cnt = 0;
   int unsigned ferr_cnt = 0;
   int unsigned ovr_cnt = 0;
   int unsigned cerr_cnt = 0;
   int unsigned base;

   uart_rx_stream_decoder #(
      .BAUDDIV    (16),
      .FIFO_DEPTH (8),
      .FIFO_AW    (3)
   ) dut (
      .CLK                 (clk),
      .RST                 (rst),
      .RXD                 (rxd),
      .RX_DATA             (rx_data),
      .RX_VALID            (rx_valid),
      .RX_READY            (rx_ready),
      .FIFO_LEVEL          (fifo_level),
      .DEBUG_TESTER_ENABLE (dte),
      .EOT                 (eot),
      .FRAME_ERR           (frame_err),
      .OVERRUN             (overrun),
      .CMD_ERR             (cmd_err)
   );

   always #5 clk = ~clk;

   // Pulse outputs are tallied in cycles-high so a stretched pulse shows up
   always @(negedge clk) begin
      if (eot)       eot_cnt  <= eot_cnt + 1;
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if (overrun)   ovr_cnt  <= ovr_cnt + 1;
      if (cmd_err)   cerr_cnt <= cerr_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int unsigned extra_low);
      @(negedge clk);
      rxd = 1'b0;
      repeat (16) @(negedge clk);
      for (int unsigned i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (16) @(negedge clk);
      end
      rxd = stop_bit;
      repeat (16 + extra_low) @(negedge clk);
      rxd = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic pop_one();
      @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_valid"}, rx_valid, 0);
      check_eq({tag, "_level"}, fifo_level, 0);
      check_eq({tag, "_data"}, rx_data, 0);
      check_eq({tag, "_dte"}, dte, 0);
      check_eq({tag, "_pulses"}, {eot, frame_err, overrun, cmd_err}, 0);
   endtask

   initial begin
      logic [7:0] ch;
      repeat (4) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Two characters held, then popped one at a time
      send_byte(8'h41, 1'b1, 0);
      send_byte(8'h5A, 1'b1, 0);
      check_eq("two_valid", rx_valid, 1);
      check_eq("two_level", fifo_level, 2);
      check_eq("two_head", rx_data, 8'h41);
      pop_one();
      check_eq("pop1_head", rx_data, 8'h5A);
      check_eq("pop1_level", fifo_level, 1);
      pop_one();
      check_eq("pop2_valid", rx_valid, 0);

      // Escape commands
      send_byte(8'h1B, 1'b1, 0);
      send_byte(8'h11, 1'b1, 0);
      check_eq("esc_on_dte", dte, 1);
      check_eq("esc_on_level", fifo_level, 0);
      send_byte(8'h1B, 1'b1, 0);
      send_byte(8'h12, 1'b1, 0);
      check_eq("esc_off_dte", dte, 0);
      base = cerr_cnt;
      send_byte(8'h1B, 1'b1, 0);
      send_byte(8'h55, 1'b1, 0);
      check_eq("cmd_err_pulses", cerr_cnt - base, 1);
      check_eq("cmd_err_level", fifo_level, 0);
      check_eq("cmd_err_dte", dte, 0);

      // End-of-text is both pulsed and stored
      base = eot_cnt;
      send_byte(8'h04, 1'b1, 0);
      check_eq("eot_pulses", eot_cnt - base, 1);
      check_eq("eot_level", fifo_level, 1);
      check_eq("eot_data", rx_data, 8'h04);
      pop_one();

      // Bad stop bit followed by a stuck-low line, then a clean frame
      base = ferr_cnt;
      send_byte(8'h33, 1'b0, 40);
      check_eq("ferr_pulses", ferr_cnt - base, 1);
      check_eq("ferr_level", fifo_level, 0);
      send_byte(8'h33, 1'b1, 0);
      check_eq("ferr_recover_data", rx_data, 8'h33);
      check_eq("ferr_recover_level", fifo_level, 1);
      check_eq("ferr_no_second", ferr_cnt - base, 1);
      pop_one();

      // Fill past capacity
      base = ovr_cnt;
      for (int unsigned i = 0; i < 8; i++) send_byte(8'(8'h30 + i), 1'b1, 0);
      check_eq("fill_level", fifo_level, 8);
      check_eq("fill_no_ovr", ovr_cnt - base, 0);
      send_byte(8'h38, 1'b1, 0);
      check_eq("ovr_pulses", ovr_cnt - base, 1);
      check_eq("ovr_level", fifo_level, 8);
      for (int unsigned i = 0; i < 8; i++) begin
         ch = 8'(8'h30 + i);
         check_eq($sformatf("pop_order_%0d", i), rx_data, ch);
         pop_one();
      end
      check_eq("drain_valid", rx_valid, 0);

      // Short glitch is rejected as a false start
      base = ferr_cnt;
      @(negedge clk);
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      rxd = 1'b1;
      repeat (30) @(negedge clk);
      check_eq("glitch_ferr", ferr_cnt - base, 0);
      check_eq("glitch_level", fifo_level, 0);

      // Put state in place, then reset in the middle of bit 3 of 0x7E
      send_byte(8'h1B, 1'b1, 0);
      send_byte(8'h11, 1'b1, 0);
      send_byte(8'h55, 1'b1, 0);
      check_eq("pre_rst_dte", dte, 1);
      check_eq("pre_rst_level", fifo_level, 1);
      @(negedge clk);
      rxd = 1'b0;
      repeat (16) @(negedge clk);
      rxd = 1'b0;
      repeat (16) @(negedge clk);
      rxd = 1'b1;
      repeat (32) @(negedge clk);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      rxd = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("mid_rst");
      rst = 1'b0;
      repeat (4) @(negedge clk);
      send_byte(8'h7E, 1'b1, 0);
      check_eq("post_rst_data", rx_data, 8'h7E);
      check_eq("post_rst_level", fifo_level, 1);
      check_eq("post_rst_dte", dte, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_rx_stream_decoder.md
Name: uart_rx_stream_decoder

Overview:
- Synthesizable UART receiver that consumes the MCU's UART0 TXD line, the same line the UART capture device taps.
- Deserialises 8N1 frames and strips the in-band escape command bytes: ESC 0x1B, then 0x11 or 0x12.
- Drives DEBUG_TESTER_ENABLE and an end-of-text pulse from the decoded stream.
- Buffers ordinary characters in a small FIFO for a downstream consumer, e.g. a console bridge or an LED/status logger on the zed board.

Parameters:
- BAUDDIV, 16, CLK cycles per bit; legal range 4..65535.
- FIFO_DEPTH, 8, character FIFO entries; power of two, 2..64.
- FIFO_AW, 3, log2(FIFO_DEPTH).

Ports:
- CLK  input  1  system clock
- RST  input  1  asynchronous reset, active-high
- RXD  input  1  serial input, idle high; asynchronous to CLK
- RX_DATA  output  8  FIFO head character
- RX_VALID  output  1  FIFO non-empty
- RX_READY  input  1  consumer pops head when RX_VALID&RX_READY
- FIFO_LEVEL  output  FIFO_AW+1  current occupancy
- DEBUG_TESTER_ENABLE  output  1  level set/cleared by escape commands
- EOT  output  1  one-cycle pulse when 0x04 received
- FRAME_ERR  output  1  one-cycle pulse on bad stop bit
- OVERRUN  output  1  one-cycle pulse when a character is dropped because the FIFO is full
- CMD_ERR  output  1  one-cycle pulse on unknown byte after ESC

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, rx FSM IDLE, cmd FSM NORMAL, synchroniser flops set to 1.
- RXD passes through a 2-flop synchroniser (rxd_s) before any use; 2-cycle input latency.
- The rx FSM uses a 16-bit down-counter cnt.
- IDLE: when rxd_s==0, load cnt=BAUDDIV/2-1 and go START.
- START: at cnt==0 sample rxd_s.
  - If 1: false start, return to IDLE, no pulse.
  - If 0: load cnt=BAUDDIV-1, bit index=0, go DATA.
- DATA: at cnt==0 shift rxd_s into bit[idx], LSB first, and reload cnt. After bit 7, go STOP.
- STOP: at cnt==0 sample rxd_s.
  - If 1: byte_done pulse, go IDLE.
  - If 0: FRAME_ERR pulse, byte discarded, go BREAK.
- BREAK: wait for rxd_s==1, then IDLE. A stuck-low line gives no further pulses.
- Every sample point is at mid-bit, nominally BAUDDIV/2 cycles after the edge.
- byte_done feeds the cmd FSM in the same cycle; the visible effect appears on the next edge.
- NORMAL:
  - 0x1B goes to ESC and is not stored.
  - 0x04 pulses EOT and is also pushed.
  - Any other byte is pushed.
- ESC:
  - 0x11 sets DEBUG_TESTER_ENABLE=1.
  - 0x12 clears it to 0.
  - 0x1B stays in ESC and is not stored.
  - Anything else pulses CMD_ERR and is discarded.
  - Returns to NORMAL, except on 0x1B.
- A FRAME_ERR while in ESC returns the cmd FSM to NORMAL.
- FIFO:
  - Push when full: character dropped, OVERRUN pulse, contents unchanged.
  - Simultaneous push and pop when full: pop occurs and the push is accepted, no OVERRUN.
  - Simultaneous push and pop when empty: push only; RX_VALID rises next cycle.
- RX_DATA is the registered head, valid whenever RX_VALID=1. It is stable while RX_VALID&!RX_READY.
- FIFO_LEVEL is exact, 0..FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH with an extra wrap bit for the full/empty distinction.
- Latency: EOT, DEBUG_TESTER_ENABLE and RX_VALID change 1 cycle after byte_done. byte_done is ~9.5 bit-times + 2 cycles after the start edge.
- RST asserted mid-frame: immediate return to reset state; the partial byte is lost.
- After RST release with RXD low: the FSM enters START and treats it as a frame. The bench must hold RXD high across reset.

Test Plan:
- BAUDDIV=16, send 0x41 then 0x5A, RX_READY=0 -> RX_VALID=1, FIFO_LEVEL=2, RX_DATA=0x41; one pop -> RX_DATA=0x5A, level 1.
- Send 0x1B,0x11 -> DEBUG_TESTER_ENABLE=1, FIFO_LEVEL stays 0; then 0x1B,0x12 -> DEBUG_TESTER_ENABLE=0; then 0x1B,0x55 -> CMD_ERR one pulse, level 0.
- Send 0x04 -> EOT high for exactly one cycle and FIFO holds 0x04.
- Frame 0x33 with stop bit driven 0, RXD held low 40 cycles -> one FRAME_ERR pulse, no push, no second pulse; a following 0x33 is received normally.
- RX_READY=0, send 9 bytes 0x30..0x38 -> level 8, OVERRUN pulses once on 0x38; pop order 0x30..0x37.
- 4-cycle low glitch on RXD -> no FRAME_ERR, no push, FSM back in IDLE. Then assert RST mid-frame at bit 3 -> all outputs 0; the next full frame 0x7E is received correctly.
